// File: rtl/std_lane_tx_framer_if.sv
// std_lane_tx_framer_if: descriptor, upstream-word and stack-bus lane signals of one framer lane
interface std_lane_tx_framer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic                  cfg_valid;
    logic [LEN_WIDTH-1:0]  cfg_num_words;
    logic                  cfg_ready;
    logic                  rf_valid;
    logic [DATA_WIDTH-1:0] rf_data;
    logic                  rf_ready;
    logic                  std_valid;
    logic [1:0]            std_cntl;
    logic [DATA_WIDTH-1:0] std_data;
    logic                  std_ready;
    logic                  busy;
    logic                  cfg_len_err;

    modport master (
        output cfg_valid, cfg_num_words, rf_valid, rf_data, std_ready,
        input  cfg_ready, rf_ready, std_valid, std_cntl, std_data, busy, cfg_len_err
    );

    modport slave (
        input  cfg_valid, cfg_num_words, rf_valid, rf_data, std_ready,
        output cfg_ready, rf_ready, std_valid, std_cntl, std_data, busy, cfg_len_err
    );
endinterface

// File: rtl/std_lane_tx_framer.sv
// std_lane_tx_framer: buffers lane words in a FIFO and emits them as SOM/MOM/EOM framed messages
module std_lane_tx_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_poweron,
    std_lane_tx_framer_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wptr, r_rptr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_first, r_len_err;
    logic                  w_empty, w_full, w_push, w_pop, w_cfg_acc, w_cfg_zero, w_last;
    logic                  w_cfg_ready, w_busy, w_std_valid;
    logic [1:0]            w_std_cntl;
    logic [DATA_WIDTH-1:0] w_std_data;

    assign w_empty    = r_wptr == r_rptr;
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push     = bus.rf_valid && !w_full;
    assign w_pop      = w_std_valid && bus.std_ready;
    assign w_cfg_acc  = bus.cfg_valid && w_cfg_ready;
    assign w_cfg_zero = bus.cfg_num_words == '0;
    assign w_last     = r_remaining == LEN_WIDTH'(1);

    assign bus.cfg_ready   = w_cfg_ready;
    assign bus.rf_ready    = !w_full;
    assign bus.std_valid   = w_std_valid;
    assign bus.std_cntl    = w_std_cntl;
    assign bus.std_data    = w_std_data;
    assign bus.busy        = w_busy;
    assign bus.cfg_len_err = r_len_err;

    // state register
    always_ff @(posedge clk) begin
        if (reset_poweron) r_state <= IDLE;
        else               r_state <= w_next;
    end

    // next state: start on a non-zero descriptor, finish when the last word is taken
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = (w_cfg_acc && !w_cfg_zero) ? SEND : IDLE;
        else                 w_next = (w_pop && w_last) ? IDLE : SEND;
    end

    // outputs: lane word is only driven while sending with data available, else zeroed
    always_comb begin
        w_cfg_ready = (r_state == IDLE) && !reset_poweron;
        w_busy      = r_state == SEND;
        w_std_valid = (r_state == SEND) && !w_empty;
        w_std_cntl  = !w_std_valid        ? 2'b00 :
                      (r_first && w_last) ? 2'b00 :
                      r_first             ? 2'b01 :
                      w_last              ? 2'b11 : 2'b10;
        w_std_data  = w_std_valid ? r_mem[r_rptr[AW-1:0]] : '0;
    end

    // FIFO storage, written at the tail on every accepted upstream word
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= bus.rf_data;
    end

    // FIFO pointers with an extra wrap bit to tell full from empty
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // message progress: words left and whether the next word opens the message
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            r_remaining <= '0;
            r_first     <= 1'b0;
        end else if (w_cfg_acc && !w_cfg_zero) begin
            r_remaining <= bus.cfg_num_words;
            r_first     <= 1'b1;
        end else if (w_pop) begin
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            r_first     <= 1'b0;
        end
    end

    // one-cycle flag for a dropped zero-length descriptor
    always_ff @(posedge clk) begin
        if (reset_poweron) r_len_err <= 1'b0;
        else               r_len_err <= w_cfg_acc && w_cfg_zero;
    end
endmodule

// File: tb/tb_std_lane_tx_framer.sv
// tb_std_lane_tx_framer: scoreboard bench with directed scenarios and randomized message traffic
module tb_std_lane_tx_framer;
    logic clk = 1'b0;
    logic reset_poweron = 1'b1;
    int   errs = 0;
    int   checks = 0;
    int   n_xfer = 0;
    bit   done = 1'b0;

    logic [31:0] dq[$];
    logic [1:0]  cq[$];
    logic        m_lerr = 1'b0;

    always #5 clk = ~clk;

    std_lane_tx_framer_if #(.DATA_WIDTH(32), .LEN_WIDTH(16)) bus ();

    std_lane_tx_framer #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .LEN_WIDTH(16)) dut (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .bus           (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor + reference model: FIFO is a word queue, messages are a queue of framing codes
    initial forever begin
        bit          c_empty, d_room, exp_v, nxt_lerr;
        int          len;
        @(negedge clk);
        if (reset_poweron) begin
            chk("cfg_ready_in_reset", bus.cfg_ready, 0);
            dq.delete();
            cq.delete();
            m_lerr = 1'b0;
        end else begin
            c_empty = cq.size() == 0;
            d_room  = dq.size() < 8;
            exp_v   = !c_empty && dq.size() != 0;
            chk("busy", bus.busy, !c_empty);
            chk("cfg_ready", bus.cfg_ready, c_empty);
            chk("rf_ready", bus.rf_ready, d_room);
            chk("cfg_len_err", bus.cfg_len_err, m_lerr);
            chk("std_valid", bus.std_valid, exp_v);
            chk("std_data", bus.std_data, exp_v ? dq[0] : 32'h0);
            chk("std_cntl", bus.std_cntl, exp_v ? cq[0] : 2'b00);
            nxt_lerr = 1'b0;
            if (exp_v && bus.std_ready) begin
                void'(dq.pop_front());
                void'(cq.pop_front());
                n_xfer++;
            end
            if (bus.rf_valid && d_room) dq.push_back(bus.rf_data);
            if (bus.cfg_valid && c_empty) begin
                len = int'(bus.cfg_num_words);
                if (len == 0) nxt_lerr = 1'b1;
                for (int i = 0; i < len; i++)
                    cq.push_back(len == 1 ? 2'b00 : i == 0 ? 2'b01 : i == len - 1 ? 2'b11 : 2'b10);
            end
            m_lerr = nxt_lerr;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        bit acc;
        int n = 0;
        bus.rf_valid = 1'b1;
        bus.rf_data  = d;
        do begin
            @(negedge clk);
            acc = bus.rf_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 2000);
        bus.rf_valid = 1'b0;
        bus.rf_data  = '0;
        if (!acc) chk("push_timeout", 32'(acc), 1);
    endtask

    task automatic cfg(input int len);
        bit acc;
        int n = 0;
        bus.cfg_valid     = 1'b1;
        bus.cfg_num_words = 16'(len);
        do begin
            @(negedge clk);
            acc = bus.cfg_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 2000);
        bus.cfg_valid     = 1'b0;
        bus.cfg_num_words = '0;
        if (!acc) chk("cfg_timeout", 32'(acc), 1);
    endtask

    task automatic wait_xfer(input int target);
        int n = 0;
        while (n_xfer < target && n < 1000) begin
            cyc(1);
            n++;
        end
        if (n_xfer < target) chk("xfer_timeout", 32'(n_xfer), 32'(target));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cq.size() != 0 && n < 3000) begin
            cyc(1);
            n++;
        end
        if (cq.size() != 0) chk("drain_timeout", 32'(cq.size()), 0);
        cyc(2);
    endtask

    // stimulus
    initial begin
        int start;
        int lens[40];
        int total;
        bus.cfg_valid = 1'b0; bus.cfg_num_words = '0;
        bus.rf_valid  = 1'b0; bus.rf_data = '0;
        bus.std_ready = 1'b0;
        cyc(3);
        reset_poweron = 1'b0;
        cyc(2);
        // single-word message
        bus.std_ready = 1'b1;
        cfg(1);
        push(32'hA5);
        wait_idle();
        // four-word message streaming back to back
        cfg(4);
        for (int i = 1; i <= 4; i++) push(32'(i));
        wait_idle();
        // prefetch until full, hold a ninth word, then drain
        for (int i = 0; i < 8; i++) push(32'h100 + 32'(i));
        bus.rf_valid = 1'b1;
        bus.rf_data  = 32'h108;
        cyc(3);
        start = n_xfer;
        cfg(8);
        push(32'h108);
        wait_xfer(start + 8);
        chk("t3_drained", 32'(n_xfer - start), 8);
        cfg(1);
        wait_idle();
        // stalled output with toggling ready
        bus.std_ready = 1'b0;
        cfg(3);
        for (int i = 0; i < 3; i++) push(32'hC0 + 32'(i));
        start = n_xfer;
        for (int n = 0; n < 100 && n_xfer < start + 3; n++) begin
            bus.std_ready = ~bus.std_ready;
            cyc(1);
        end
        cyc(5);
        chk("t4_xfers", 32'(n_xfer - start), 3);
        bus.std_ready = 1'b1;
        wait_idle();
        // zero-length descriptor is dropped
        cfg(0);
        cyc(3);
        // reset in the middle of a message
        bus.std_ready = 1'b0;
        cfg(5);
        for (int i = 0; i < 5; i++) push(32'hE0 + 32'(i));
        start = n_xfer;
        bus.std_ready = 1'b1;
        wait_xfer(start + 2);
        reset_poweron = 1'b1;
        cyc(2);
        reset_poweron = 1'b0;
        cyc(2);
        chk("t6_busy_after_reset", bus.busy, 0);
        cfg(2);
        push(32'hF0);
        push(32'hF1);
        wait_idle();
        // randomized traffic
        total = 0;
        for (int i = 0; i < 40; i++) begin
            lens[i] = int'($urandom_range(0, 6));
            total += lens[i];
        end
        fork
            begin
                fork
                    for (int i = 0; i < 40; i++) begin
                        cfg(lens[i]);
                        cyc(int'($urandom_range(0, 2)));
                    end
                    for (int i = 0; i < total; i++) begin
                        push($urandom);
                        if ($urandom_range(0, 3) == 0) cyc(int'($urandom_range(1, 3)));
                    end
                join
                done = 1'b1;
            end
            while (!done) begin
                bus.std_ready = $urandom_range(0, 3) != 0;
                cyc(1);
            end
        join
        bus.std_ready = 1'b1;
        wait_idle();
        chk("final_fifo_empty", 32'(dq.size()), 0);
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
